// File: rtl/trap_arbiter_if.sv
// +----------------------------------------------------------------------+
// | trap_arbiter_if : stage exception / trap request bundle, rev 1.0    |
// +----------------------------------------------------------------------+
`default_nettype none

interface trap_arbiter_if;
  logic        id_v, ex_v, mem_v;
  logic [31:0] id_pc, ex_pc, mem_pc;
  logic        id_exc, ex_exc, mem_exc;
  logic [31:0] id_cause, ex_cause, mem_cause;
  logic        mret_wb;
  logic        mstatus_mie;
  logic        mie_meie;
  logic        irq_async;
  logic        take_trap;
  logic        take_trap_raw;
  logic        trap_set;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        flush_id, flush_ex, flush_mem;
  logic        intr_synced;
  logic        cu_intr_ack;

  modport master (
    output id_v, ex_v, mem_v, id_pc, ex_pc, mem_pc,
    output id_exc, ex_exc, mem_exc, id_cause, ex_cause, mem_cause,
    output mret_wb, mstatus_mie, mie_meie, irq_async, take_trap,
    input  take_trap_raw, trap_set, trap_cause, trap_pc,
    input  flush_id, flush_ex, flush_mem, intr_synced, cu_intr_ack
  );

  modport slave (
    input  id_v, ex_v, mem_v, id_pc, ex_pc, mem_pc,
    input  id_exc, ex_exc, mem_exc, id_cause, ex_cause, mem_cause,
    input  mret_wb, mstatus_mie, mie_meie, irq_async, take_trap,
    output take_trap_raw, trap_set, trap_cause, trap_pc,
    output flush_id, flush_ex, flush_mem, intr_synced, cu_intr_ack
  );
endinterface

`default_nettype wire

// File: rtl/trap_arbiter.sv
// +----------------------------------------------------------------------+
// | trap_arbiter : program-order trap selection for the CSR adapter      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module trap_arbiter #(
  parameter logic [31:0] IRQ_CAUSE     = 32'h8000_000B,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  trap_arbiter_if.slave  bus
);

  localparam int unsigned SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  typedef logic [SW-1:0] settle_t;
  localparam settle_t SETTLE_LOAD = settle_t'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t  state_q, state_d;
  settle_t settle_q, settle_d;
  logic    sync1_q, sync2_q, sync2_dly_q;
  logic    irq_pending_q, irq_pending_d;

  logic        mem_hit, ex_hit, id_hit, any_v, irq_ok;
  logic        issue, irq_issue;
  logic [31:0] cause, pc;
  logic        fl_mem, fl_ex, fl_id;

  assign mem_hit = bus.mem_v & bus.mem_exc;
  assign ex_hit  = bus.ex_v  & bus.ex_exc;
  assign id_hit  = bus.id_v  & bus.id_exc;
  assign any_v   = bus.mem_v | bus.ex_v | bus.id_v;
  assign irq_ok  = (state_q == ST_IDLE) & irq_pending_q & bus.mstatus_mie & bus.mie_meie
                 & ~bus.mret_wb & (settle_q == '0) & any_v;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    issue     = 1'b0;
    irq_issue = 1'b0;
    cause     = '0;
    pc        = '0;
    fl_mem    = 1'b0;
    fl_ex     = 1'b0;
    fl_id     = 1'b0;

    // While waiting for the redirect, younger exceptions are wrong-path.
    if (state_q != ST_WAIT) begin
      if (mem_hit) begin
        issue = 1'b1; cause = bus.mem_cause; pc = bus.mem_pc;
        fl_mem = 1'b1; fl_ex = 1'b1; fl_id = 1'b1;
      end else if (ex_hit) begin
        issue = 1'b1; cause = bus.ex_cause; pc = bus.ex_pc;
        fl_ex = 1'b1; fl_id = 1'b1;
      end else if (id_hit) begin
        issue = 1'b1; cause = bus.id_cause; pc = bus.id_pc;
        fl_id = 1'b1;
      end else if (irq_ok) begin
        issue = 1'b1; irq_issue = 1'b1; cause = IRQ_CAUSE;
        if (bus.mem_v) begin
          pc = bus.mem_pc; fl_mem = 1'b1; fl_ex = 1'b1; fl_id = 1'b1;
        end else if (bus.ex_v) begin
          pc = bus.ex_pc; fl_ex = 1'b1; fl_id = 1'b1;
        end else begin
          pc = bus.id_pc; fl_id = 1'b1;
        end
      end
    end

    case (state_q)
      ST_WAIT: begin
        fl_mem = 1'b1; fl_ex = 1'b1; fl_id = 1'b1;
        if (bus.take_trap) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_IDLE, ST_SETTLE: begin
        if (issue) begin
          // The adapter may return the redirect in the issue cycle itself.
          state_d  = bus.take_trap ? ST_SETTLE : ST_WAIT;
          settle_d = bus.take_trap ? SETTLE_LOAD : '0;
        end else if (state_q == ST_SETTLE) begin
          settle_d = (settle_q == '0) ? '0 : settle_q - settle_t'(1);
          if (settle_q <= settle_t'(1)) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = '0;
      end
    endcase
  end

  assign irq_pending_d = (sync2_q & ~sync2_dly_q) | (irq_pending_q & ~irq_issue);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      settle_q      <= '0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync2_dly_q   <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      sync1_q       <= bus.irq_async;
      sync2_q       <= sync1_q;
      sync2_dly_q   <= sync2_q;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign bus.take_trap_raw = issue;
  assign bus.trap_set      = issue;
  assign bus.trap_cause    = cause;
  assign bus.trap_pc       = pc;
  assign bus.flush_mem     = fl_mem;
  assign bus.flush_ex      = fl_ex;
  assign bus.flush_id      = fl_id;
  assign bus.intr_synced   = sync2_q;
  assign bus.cu_intr_ack   = irq_issue;

endmodule

`default_nettype wire
